// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types and helpers for the sequential M/N-bit divider.
//  Revision : 1.0  initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // Width of the step counter that walks the M quotient bits.
    function automatic int cnt_w(input int m);
        return $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One restoring-division step: shift in a dividend bit, trial
//             subtract the divisor, keep the difference if it did not borrow.
//  Revision : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   r_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_out,
    output logic         q_bit
);

    logic [N:0] r_shift;
    logic [N:0] diff;
    logic       no_borrow;

    assign r_shift = {r_in[N-1:0], bit_in};

    // r_shift - divisor as r_shift + ~divisor + 1; carry-out set means no borrow.
    rca_Nbit_co #(.N(N + 1)) u_sub (
        .a   (r_shift),
        .b   (~{1'b0, divisor}),
        .cin (1'b1),
        .sum (diff),
        .co  (no_borrow)
    );

    // A set r_in[N] means the shifted value exceeds N+1 bits, so it is surely >= divisor.
    assign q_bit = r_in[N] | no_borrow;
    assign r_out = q_bit ? diff : r_shift;

endmodule
`default_nettype wire

// File: rtl/rca_Nbit_co.sv
`default_nettype none
// ============================================================================
//  Module   : rca_Nbit_co
//  Purpose  : N-bit ripple-carry adder with carry-in and carry-out.
//  Revision : 1.0  initial release
// ============================================================================
module rca_Nbit_co #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         co
);

    logic carry;

    // Ripple the carry from LSB to MSB one full-adder at a time.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule
`default_nettype wire

// File: rtl/div_mnbit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_mnbit_seq
//  Purpose  : Iterative restoring divider, M-bit dividend / N-bit divisor,
//             one quotient bit per clock, start/done handshake.
//  Options  : DIV_SIGNED_EN - two's-complement operands/results (truncating
//             division, remainder takes the dividend's sign).
//  Revision : 1.0  initial release
// ============================================================================
module div_mnbit_seq
    import div_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_w(M);

    div_state_t   state;
    logic [CW-1:0] count;
    logic [M-1:0] dvd_sh;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [N:0]   rem_p;
    logic [N-1:0] dsr;

    logic         accept;
    logic [N:0]   step_r;
    logic         step_q;
    logic [M-1:0] q_final;
    logic [N-1:0] r_final;
    logic [M-1:0] mag_dvd;
    logic [N-1:0] mag_dsr;
    logic [M-1:0] q_out;
    logic [N-1:0] r_out;

    assign accept  = start && (state != S_RUN);
    assign q_final = {dvd_sh[M-2:0], step_q};
    assign r_final = step_r[N-1:0];

    div_step #(.N(N)) u_step (
        .r_in    (rem_p),
        .bit_in  (dvd_sh[M-1]),
        .divisor (dsr),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // The unsigned core works on magnitudes; most-negative maps to its own bit pattern.
    assign mag_dvd = dividend[M-1] ? (M'(0) - dividend) : dividend;
    assign mag_dsr = divisor[N-1]  ? (N'(0) - divisor)  : divisor;
    assign q_out   = neg_q ? (M'(0) - q_final) : q_final;
    assign r_out   = neg_r ? (N'(0) - r_final) : r_final;

    // Remember result signs at accept since the operand inputs may change afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[M-1] ^ divisor[N-1];
            neg_r <= dividend[M-1];
        end
    end
`else
    assign mag_dvd = dividend;
    assign mag_dsr = divisor;
    assign q_out   = q_final;
    assign r_out   = r_final;
`endif

    // Control FSM, step counter, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            dvd_sh      <= '0;
            rem_p       <= '0;
            dsr         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        count       <= '0;
                        rem_p       <= '0;
                        dvd_sh      <= mag_dvd;
                        dsr         <= mag_dsr;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            // No iteration needed: report the fixed divide-by-zero result next cycle.
                            state       <= S_DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem_p  <= step_r;
                    dvd_sh <= q_final;
                    count  <= count + 1'b1;
                    if (count == CW'(M - 1)) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_out;
                        remainder <= r_out;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_mnbit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_mnbit_seq
//  Purpose  : Scoreboard bench for div_mnbit_seq (M=8, N=4) with a
//             plain-arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_mnbit_seq;

    localparam int M = 8;
    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [M-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [M-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    div_mnbit_seq #(.M(M), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [M-1:0] a;
        logic [N-1:0] b;
        logic [M-1:0] q;
        logic [N-1:0] r;
        logic         z;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic exp_t model(input logic [M-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e.a = a; e.b = b; e.due = 0;
        if (b == '0) begin
            e.q = '1; e.r = a[N-1:0]; e.z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa, sb_v, qi, ri;
            sa   = int'($signed(a));
            sb_v = int'($signed(b));
            qi   = sa / sb_v;
            ri   = sa % sb_v;
            e.q  = M'(qi);
            e.r  = N'(ri);
`else
            e.q = M'(int'(a) / int'(b));
            e.r = N'(int'(a) % int'(b));
`endif
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Wait for an accepting cycle, present one request, and log its expected result.
    task automatic issue(input logic [M-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("accept_timeout", 1, 0);
            return;
        end
        e     = model(a, b);
        e.due = cyc + 1 + ((b == '0) ? 0 : M);
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = M'($urandom);
        divisor  = N'($urandom);
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.z);
                chk("done_cycle", cyc, e.due);
                if (e.b != '0) begin
`ifdef DIV_SIGNED_EN
                    chk("round_trip", M'(int'($signed(quotient)) * int'($signed(e.b))
                                         + int'($signed(remainder))), e.a);
`else
                    chk("round_trip", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
                    chk("rem_lt_div", (remainder < e.b) ? 1 : 0, 1);
`endif
                end
            end
        end
    end

    initial begin
        int d0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // 100/7 with busy window: high for M cycles after accept, then low on done.
        issue(8'd100, 4'd7);
        for (int i = 0; i < M; i++) begin
            chk("busy_window", busy, 1);
            @(negedge clk);
        end
        chk("busy_end", busy, 0);
        chk("done_end", done, 1);

        // Back-to-back from the done cycle; zero divisor then clearing flag.
        issue(8'd255, 4'd1);
        issue(8'd5, 4'd9);
        issue(8'd77, 4'd0);
        issue(8'd77, 4'd7);

        // start mid-run with new operands must be ignored.
        issue(8'd100, 4'd7);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;

`ifdef DIV_SIGNED_EN
        issue(8'h9C, 4'h7);   // -100 / 7
        issue(8'h80, 4'hF);   // -128 / -1
        issue(8'h64, 4'hD);   // 100 / -3
`endif

        // Reset asserted four edges after accept abandons the operation.
        issue(8'd50, 4'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        d0 = n_done;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_dbz", div_by_zero, 0);
        rst = 1'b0;
        repeat (M + 2) @(negedge clk);
        chk("midrst_no_done", n_done, d0);

        // Randomised operands, occasional zero divisors and idle gaps.
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] b;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom);
            issue(M'($urandom), b);
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
